// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC sequencing, fetch handshake, misaligned-target fault
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clrn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic [1:0]  pcsrc,
  input  logic [31:0] rs_data,
  input  logic        commit,
  output logic        instr_valid,
  output logic [31:0] inst,
  output logic [5:0]  op,
  output logic [5:0]  func,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        fault
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, FAULT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] br_off;
  logic [31:0] next_pc;

  assign pc        = pc_q;
  assign pc4       = pc_q + 32'd4;
  assign inst      = inst_q;
  assign op        = inst_q[31:26];
  assign func      = inst_q[5:0];
  assign imem_addr = pc_q;
  assign br_off    = {{14{inst_q[15]}}, inst_q[15:0], 2'b00};

  always_comb begin
    next_pc = pc4;
    case (pcsrc)
      2'b00:   next_pc = pc4;
      2'b01:   next_pc = pc4 + br_off;
      2'b10:   next_pc = rs_data;
      default: next_pc = {pc4[31:28], inst_q[25:0], 2'b00};
    endcase
  end

  // pcsrc/rs_data only matter through next_pc, which is consumed solely on an EXEC commit
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    fault       = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          inst_d  = imem_rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        instr_valid = 1'b1;
        if (commit) begin
          if (next_pc[1:0] != 2'b00) begin
            state_d = FAULT;
          end else begin
            pc_d    = next_pc;
            state_d = FETCH;
          end
        end
      end
      FAULT: begin
        fault = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC loaded on reset; SHALL be word-aligned.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 clrn  in  1  reset, asynchronous, active-low.
REQ-004 imem_req  out  1  instruction-memory read request.
REQ-005 imem_addr  out  32  read address; SHALL equal pc while imem_req=1.
REQ-006 imem_ack  in  1  memory returns imem_rdata valid this cycle.
REQ-007 imem_rdata  in  32  instruction word.
REQ-008 pcsrc  in  2  next-PC select from control: 00 pc4, 01 branch, 10 jr, 11 jump.
REQ-009 rs_data  in  32  register rs value, jr target.
REQ-010 commit  in  1  datapath has finished the current instruction; advance PC.
REQ-011 instr_valid  out  1  inst/op/func hold a fetched, uncommitted instruction.
REQ-012 inst  out  32  instruction register.
REQ-013 op  out  6  inst[31:26]; func  out  6  inst[5:0] (both combinational from inst).
REQ-014 pc  out  32  address of inst; pc4  out  32  pc+4.
REQ-015 fault  out  1  misaligned next-PC detected; sticky.

Function
REQ-016 FSM states: IDLE, FETCH, EXEC, FAULT.
REQ-017 IDLE -> FETCH unconditionally on the first rising edge after clrn deasserts.
REQ-018 FETCH: imem_req=1 (decoded from state), imem_addr=pc; on edge with imem_ack=1, inst<=imem_rdata, go EXEC; otherwise remain, request and address held stable.
REQ-019 A fetch SHALL take at least 1 cycle; ack in the first FETCH cycle is legal (zero-wait memory).
REQ-020 EXEC: instr_valid=1, imem_req=0; inst and pc SHALL hold until commit.
REQ-021 EXEC with commit=1: compute next PC; if next[1:0]!=00 go FAULT, pc unchanged; else pc<=next, go FETCH.
REQ-022 Next PC: 00 -> pc+4; 01 -> pc+4 + (sign_extend(inst[15:0]) << 2); 10 -> rs_data; 11 -> {pc4[31:28], inst[25:0], 2'b00}.
REQ-023 All PC arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0 with no fault.
REQ-024 pcsrc and rs_data SHALL be sampled only in the EXEC cycle where commit=1.
REQ-025 commit outside EXEC and imem_ack outside FETCH SHALL be ignored with no state change.
REQ-026 FAULT: fault=1, imem_req=0, instr_valid=0, inst and pc frozen; exit only via reset.
REQ-027 Minimum throughput: one instruction per 2 cycles (FETCH + EXEC) with zero-wait memory and immediate commit.

Reset
REQ-028 clrn=0 SHALL immediately force: state=IDLE, pc=RESET_PC, inst=0, imem_req=0, instr_valid=0, fault=0; hence op=0, func=0, pc4=RESET_PC+4.
REQ-029 Reset during FETCH SHALL drop imem_req in the same cycle; the outstanding ack, if returned, is ignored.
REQ-030 Reset during EXEC SHALL discard the instruction; no PC update from a coincident commit.

Verification
REQ-031 Reset release, zero-wait memory returning 32'h2008_0005 (addi) -> req at pc=0 in cycle 1, instr_valid cycle 2, op=6'b001000; commit with pcsrc=00 -> next fetch at 0x4.
REQ-032 pc=0x100, inst beq with imm=16'hFFFE, pcsrc=01, commit -> next fetch address 0xFC; imm=16'h0003 -> 0x110.
REQ-033 pc=0x1000_0040, inst=32'h0C00_0010 (jal), pcsrc=11 -> next 0x1000_0040; pcsrc=10, rs_data=0x0000_2000 -> next 0x2000.
REQ-034 Memory stalls 3 cycles before ack -> imem_req and imem_addr stable all 4 FETCH cycles, inst captured only on ack edge; spurious ack/commit in wrong state ignored.
REQ-035 pcsrc=10, rs_data=0x0000_2002, commit -> fault=1 next cycle, pc unchanged, imem_req=0; persists until clrn=0 then pc=RESET_PC, fault=0.
REQ-036 clrn asserted mid-FETCH and mid-EXEC (between edges) -> outputs reach reset values without a clock edge; pc=0xFFFF_FFFC with pcsrc=00 -> wraps to 0x0, no fault.
